// File: rtl/data_memory_sized.sv
// data_memory_sized
//   Byte-addressed data memory for the MIPS MEM stage with a valid/ready
//   request/response handshake. Byte/half/word (and doubleword when
//   DATA_W = 64) loads and stores, byte-lane writes, sign/zero extension on
//   loads, READ_LAT cycles from accept to response. Misaligned, oversize or
//   out-of-range accesses are trapped and never touch storage.
//
// Ports
//   clk, rst       clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (one outstanding request)
//   req_write      1 = store, 0 = load
//   req_size       00 byte, 01 half, 10 word, 11 doubleword (DATA_W = 64)
//   req_unsigned   load zero-extends when 1, sign-extends when 0
//   req_addr       byte address
//   req_wdata      store data, right-aligned
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata      extended load data; 0 for stores and errors
//   rsp_err        the access was illegal
//   err_sticky     set by any illegal access, cleared by err_clr or reset
//   err_addr       address of the most recent illegal access
//   err_clr        clears err_sticky (err_addr is kept)
module data_memory_sized #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned READ_LAT = 1,
  parameter int unsigned ADDR_W   = $clog2(DEPTH * DATA_W / 8)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              err_sticky,
  output logic [ADDR_W-1:0] err_addr,
  input  logic              err_clr
);

  localparam int unsigned BYTES  = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(BYTES);
  localparam int unsigned MIDX_W = $clog2(DEPTH);
  localparam logic [1:0]  LAT_CNT = (READ_LAT > 1) ? 2'(READ_LAT - 2) : 2'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t              r_state;
  logic [1:0]          r_cnt;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;
  logic                r_err_sticky;
  logic [ADDR_W-1:0]   r_err_addr;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_req_ready;
  logic                w_accept;
  logic                w_consume;
  state_t              w_first;
  logic [OFF_W-1:0]    w_off;
  logic [OFF_W+2:0]    w_bitoff;
  logic [3:0]          w_nbytes;
  logic [6:0]          w_nbits;
  logic [ADDR_W-1:0]   w_widx_full;
  logic [MIDX_W-1:0]   w_idx;
  logic                w_misalign;
  logic                w_bad_size;
  logic                w_oor;
  logic                w_illegal;
  logic                w_we;
  logic [BYTES-1:0]    w_bmask;
  logic [DATA_W-1:0]   w_wdata_sh;
  logic [DATA_W-1:0]   w_word;
  logic [DATA_W-1:0]   w_rd_sh;
  logic [DATA_W-1:0]   w_keep;
  logic                w_sign;
  logic                w_sext;
  logic [DATA_W-1:0]   w_ld;

  // ------------------------------------------------------------------
  // Address decode and legality
  // ------------------------------------------------------------------
  assign w_off       = req_addr[OFF_W-1:0];
  assign w_bitoff    = {w_off, 3'b000};
  assign w_nbytes    = 4'd1 << req_size;
  assign w_nbits     = 7'd8 << req_size;
  assign w_widx_full = req_addr >> OFF_W;
  assign w_idx       = req_addr[OFF_W +: MIDX_W];

  assign w_misalign = (w_off & OFF_W'(w_nbytes - 4'd1)) != '0;
  assign w_bad_size = (req_size == 2'b11) && (DATA_W < 64);
  // Only reachable when ADDR_W is widened beyond the memory footprint.
  assign w_oor      = 32'(w_widx_full) >= DEPTH;
  assign w_illegal  = w_misalign | w_bad_size | w_oor;

  assign w_accept = req_valid & w_req_ready;
  assign w_we     = w_accept & req_write & ~w_illegal;

  // ------------------------------------------------------------------
  // Store lane steering
  // ------------------------------------------------------------------
  assign w_bmask    = ~({BYTES{1'b1}} << w_nbytes) << w_off;
  assign w_wdata_sh = req_wdata << w_bitoff;

  // ------------------------------------------------------------------
  // Load alignment and extension
  // ------------------------------------------------------------------
  assign w_word  = r_mem[w_idx];
  assign w_rd_sh = w_word >> w_bitoff;
  // Shift by DATA_W yields zero, so a full-width access keeps every bit.
  assign w_keep  = ~({DATA_W{1'b1}} << w_nbits);

  always_comb begin
    w_sign = 1'b0;
    case (req_size)
      2'b00:   w_sign = w_rd_sh[7];
      2'b01:   w_sign = w_rd_sh[15];
      2'b10:   w_sign = w_rd_sh[31];
      default: w_sign = w_rd_sh[DATA_W-1];
    endcase
  end

  assign w_sext = w_sign & ~req_unsigned;
  assign w_ld   = (w_rd_sh & w_keep) | ({DATA_W{w_sext}} & ~w_keep);

  // ------------------------------------------------------------------
  // Handshake
  // ------------------------------------------------------------------
  always_comb begin
    w_req_ready = 1'b0;
    case (r_state)
      S_IDLE:  w_req_ready = 1'b1;
      S_WAIT:  w_req_ready = 1'b0;
      S_RESP:  w_req_ready = rsp_ready;
      default: w_req_ready = 1'b0;
    endcase
  end

  assign w_consume = (r_state == S_RESP) & rsp_ready;
  assign w_first   = (READ_LAT > 1) ? S_WAIT : S_RESP;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= '0;
      r_rsp_err    <= 1'b0;
      r_err_sticky <= 1'b0;
      r_err_addr   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state     <= w_first;
            r_rsp_valid <= (w_first == S_RESP);
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        S_RESP: begin
          if (w_consume) begin
            if (w_accept) begin
              r_state     <= w_first;
              r_rsp_valid <= (w_first == S_RESP);
            end else begin
              r_state     <= S_IDLE;
              r_rsp_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_rsp_valid <= 1'b0;
        end
      endcase

      // The response is captured at the accept edge and held until consumed.
      if (w_accept) begin
        r_cnt       <= LAT_CNT;
        r_rsp_err   <= w_illegal;
        r_rsp_rdata <= (req_write || w_illegal) ? '0 : w_ld;
      end

      // An illegal accept beats a simultaneous clear.
      if (w_accept && w_illegal) begin
        r_err_sticky <= 1'b1;
        r_err_addr   <= req_addr;
      end else if (err_clr) begin
        r_err_sticky <= 1'b0;
      end
    end
  end

  // ------------------------------------------------------------------
  // Storage
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_we) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (w_bmask[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
        end
      end
    end
  end

  assign req_ready  = w_req_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = r_rsp_rdata;
  assign rsp_err    = r_rsp_err;
  assign err_sticky = r_err_sticky;
  assign err_addr   = r_err_addr;

endmodule
